conv_lb1: RTL and testbench

Line-delay stage that sits directly downstream of the stage-0 line buffer in the conv pixel pipeline. It stores one full image row and emits each incoming pixel together with the pixel at the same column in the previous row. This forms the vertical tap pair consumed by the convolution window stage. It also checks row length consistency and row overflow.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_lb1_if.sv | 36 +++
 rtl/conv_line_mem.sv | 32 +++
 rtl/conv_lb1.sv | 99 +++++++++
 tb/tb_conv_lb1.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared pixel types and defaults for the conv pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef logic [7:0] pixel_t;

    localparam int LINE_MAX_DFLT = 1024;

    // Column index type at the default line length
    typedef logic [$clog2(LINE_MAX_DFLT)-1:0] col_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_lb1_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_lb1_if
// Description : Pixel stream bundle into and out of the line-delay stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_lb1_if;
    import conv_pkg::*;

    logic   pixel_vld_i;
    pixel_t pixel_dat_i;
    logic   pixel_eol_i;
    logic   pixel_eof_i;
    logic   stall_i;
    logic   pixel_vld_o;
    pixel_t pixel_dat_o;
    pixel_t pixel_above_o;
    logic   pixel_eol_o;
    logic   pixel_eof_o;
    logic   err_ovf_o;
    logic   err_len_o;

    modport slave (
        input  pixel_vld_i, pixel_dat_i, pixel_eol_i, pixel_eof_i, stall_i,
        output pixel_vld_o, pixel_dat_o, pixel_above_o, pixel_eol_o,
               pixel_eof_o, err_ovf_o, err_len_o
    );

    modport master (
        output pixel_vld_i, pixel_dat_i, pixel_eol_i, pixel_eof_i, stall_i,
        input  pixel_vld_o, pixel_dat_o, pixel_above_o, pixel_eol_o,
               pixel_eof_o, err_ovf_o, err_len_o
    );

endinterface : conv_lb1_if
`default_nettype wire

// File: rtl/conv_line_mem.sv
`default_nettype none
// ============================================================================
// Module      : conv_line_mem
// Description : Single-address row store, combinational read-before-write.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_line_mem
    import conv_pkg::*;
#(
    parameter int DEPTH  = LINE_MAX_DFLT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire pixel_t            wdat,
    output pixel_t                 rdat
);

    pixel_t r_mem [DEPTH];

    // Contents are deliberately unreset so this maps onto RAM primitives
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdat;
        end
    end

    assign rdat = r_mem[addr];

endmodule : conv_line_mem
`default_nettype wire

// File: rtl/conv_lb1.sv
`default_nettype none
// ============================================================================
// Module      : conv_lb1
// Description : One-row line delay emitting (current, above) pixel pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_lb1
    import conv_pkg::*;
#(
    parameter int LINE_MAX = LINE_MAX_DFLT
) (
    input  wire logic   clk,
    input  wire logic   arst_n,
    conv_lb1_if.slave   bus
);

    localparam int COL_W = $clog2(LINE_MAX);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(LINE_MAX - 1);

    logic             w_accept;
    logic [COL_W:0]   w_len;
    pixel_t           w_above;

    logic [COL_W-1:0] r_col;
    logic [COL_W:0]   r_width;
    logic             r_primed;
    logic             r_vld;
    pixel_t           r_dat;
    pixel_t           r_above;
    logic             r_eol;
    logic             r_eof;
    logic             r_err_ovf;
    logic             r_err_len;

    assign w_accept = bus.pixel_vld_i & ~bus.stall_i;
    assign w_len    = {1'b0, r_col} + (COL_W+1)'(1);

    conv_line_mem #(
        .DEPTH (LINE_MAX)
    ) u_mem (
        .clk  (clk),
        .we   (w_accept & arst_n),
        .addr (r_col),
        .wdat (bus.pixel_dat_i),
        .rdat (w_above)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_col     <= '0;
            r_width   <= '0;
            r_primed  <= 1'b0;
            r_vld     <= 1'b0;
            r_dat     <= '0;
            r_above   <= '0;
            r_eol     <= 1'b0;
            r_eof     <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_len <= 1'b0;
        end else if (!bus.stall_i) begin
            r_vld <= w_accept & r_primed;
            if (w_accept) begin
                r_dat   <= bus.pixel_dat_i;
                r_above <= w_above;
                r_eol   <= bus.pixel_eol_i;
                r_eof   <= bus.pixel_eof_i & bus.pixel_eol_i;

                if (bus.pixel_eol_i) begin
                    r_col <= '0;
                    if (!r_primed) begin
                        r_width  <= w_len;
                        r_primed <= 1'b1;
                    end else if (w_len != r_width) begin
                        r_err_len <= 1'b1;
                    end
                    // End of frame re-arms first-row width capture
                    if (bus.pixel_eof_i) begin
                        r_width  <= '0;
                        r_primed <= 1'b0;
                    end
                end else if (r_col == c_col_last) begin
                    r_err_ovf <= 1'b1;
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign bus.pixel_vld_o   = r_vld;
    assign bus.pixel_dat_o   = r_dat;
    assign bus.pixel_above_o = r_above;
    assign bus.pixel_eol_o   = r_eol;
    assign bus.pixel_eof_o   = r_eof;
    assign bus.err_ovf_o     = r_err_ovf;
    assign bus.err_len_o     = r_err_len;

endmodule : conv_lb1
`default_nettype wire

// File: tb/tb_conv_lb1.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_lb1
// Description : Directed self-checking bench for the conv_lb1 line delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_lb1;
    import conv_pkg::*;

    logic clk;
    logic arst_n;
    int   n_cmp;
    int   n_err;

    conv_lb1_if u_if ();

    conv_lb1 #(
        .LINE_MAX (8)
    ) u_dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic eol, input logic eof);
        u_if.pixel_vld_i = 1'b1;
        u_if.pixel_dat_i = d;
        u_if.pixel_eol_i = eol;
        u_if.pixel_eof_i = eof;
        tick();
        u_if.pixel_vld_i = 1'b0;
        u_if.pixel_eol_i = 1'b0;
        u_if.pixel_eof_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                              input logic [7:0] a, input logic e, input logic f);
        chk({tag, ".vld"}, 32'(u_if.pixel_vld_o), 32'(v));
        if (v) begin
            chk({tag, ".dat"},   32'(u_if.pixel_dat_o),   32'(d));
            chk({tag, ".above"}, 32'(u_if.pixel_above_o), 32'(a));
            chk({tag, ".eol"},   32'(u_if.pixel_eol_o),   32'(e));
            chk({tag, ".eof"},   32'(u_if.pixel_eof_o),   32'(f));
        end
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, ".vld"},   32'(u_if.pixel_vld_o),   32'd0);
        chk({tag, ".dat"},   32'(u_if.pixel_dat_o),   32'd0);
        chk({tag, ".above"}, 32'(u_if.pixel_above_o), 32'd0);
        chk({tag, ".eol"},   32'(u_if.pixel_eol_o),   32'd0);
        chk({tag, ".eof"},   32'(u_if.pixel_eof_o),   32'd0);
        chk({tag, ".ovf"},   32'(u_if.err_ovf_o),     32'd0);
        chk({tag, ".len"},   32'(u_if.err_len_o),     32'd0);
    endtask

    // Pushes a primed 4-pixel row base+0..3 and checks it against above base ab
    task automatic row4_primed(input string tag, input logic [7:0] base, input logic [7:0] ab,
                               input logic last_eof);
        for (int i = 0; i < 4; i++) begin
            push(base + 8'(i), i == 3, last_eof && i == 3);
            expect_out(tag, 1'b1, base + 8'(i), ab + 8'(i), i == 3, last_eof && i == 3);
        end
    endtask

    task automatic row4_first(input string tag, input logic [7:0] base, input logic last_eof);
        for (int i = 0; i < 4; i++) begin
            push(base + 8'(i), i == 3, last_eof && i == 3);
            expect_out(tag, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        arst_n           = 1'b0;
        u_if.pixel_vld_i = 1'b0;
        u_if.pixel_dat_i = '0;
        u_if.pixel_eol_i = 1'b0;
        u_if.pixel_eof_i = 1'b0;
        u_if.stall_i     = 1'b0;
        tick();
        tick();
        expect_zero("reset");
        arst_n = 1'b1;

        // First row primes, second row pairs with it
        row4_first("row0", 8'h10, 1'b0);
        row4_primed("row1", 8'h20, 8'h10, 1'b0);
        tick();
        chk("idle.vld", 32'(u_if.pixel_vld_o), 32'd0);

        // Stall mid-row: outputs freeze, stalled input is not consumed
        push(8'h40, 1'b0, 1'b0);
        expect_out("stall.pre0", 1'b1, 8'h40, 8'h20, 1'b0, 1'b0);
        push(8'h41, 1'b0, 1'b0);
        expect_out("stall.pre1", 1'b1, 8'h41, 8'h21, 1'b0, 1'b0);
        u_if.stall_i     = 1'b1;
        u_if.pixel_vld_i = 1'b1;
        u_if.pixel_dat_i = 8'h99;
        u_if.pixel_eol_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("stall.hold", 1'b1, 8'h41, 8'h21, 1'b0, 1'b0);
        end
        u_if.stall_i     = 1'b0;
        u_if.pixel_vld_i = 1'b0;
        u_if.pixel_eol_i = 1'b0;
        push(8'h42, 1'b0, 1'b0);
        expect_out("stall.post0", 1'b1, 8'h42, 8'h22, 1'b0, 1'b0);
        push(8'h43, 1'b1, 1'b0);
        expect_out("stall.post1", 1'b1, 8'h43, 8'h23, 1'b1, 1'b0);

        // End of frame, then re-priming row
        row4_primed("eof", 8'h50, 8'h40, 1'b1);
        row4_first("reprime", 8'h30, 1'b0);
        row4_primed("after_eof", 8'h60, 8'h30, 1'b0);

        // Short row flags a length error, following row still uses stored data
        push(8'h70, 1'b0, 1'b0);
        expect_out("len.p0", 1'b1, 8'h70, 8'h60, 1'b0, 1'b0);
        push(8'h71, 1'b0, 1'b0);
        expect_out("len.p1", 1'b1, 8'h71, 8'h61, 1'b0, 1'b0);
        chk("len.before", 32'(u_if.err_len_o), 32'd0);
        push(8'h72, 1'b1, 1'b0);
        expect_out("len.p2", 1'b1, 8'h72, 8'h62, 1'b1, 1'b0);
        chk("len.set", 32'(u_if.err_len_o), 32'd1);
        push(8'h80, 1'b0, 1'b0);
        expect_out("len.r2p0", 1'b1, 8'h80, 8'h70, 1'b0, 1'b0);
        push(8'h81, 1'b0, 1'b0);
        push(8'h82, 1'b0, 1'b0);
        expect_out("len.r2p2", 1'b1, 8'h82, 8'h72, 1'b0, 1'b0);
        push(8'h83, 1'b1, 1'b0);
        expect_out("len.r2p3", 1'b1, 8'h83, 8'h63, 1'b1, 1'b0);
        chk("len.sticky", 32'(u_if.err_len_o), 32'd1);

        // Reset mid-row clears everything and restarts priming
        push(8'hB0, 1'b0, 1'b0);
        expect_out("rst.p0", 1'b1, 8'hB0, 8'h80, 1'b0, 1'b0);
        push(8'hB1, 1'b0, 1'b0);
        expect_out("rst.p1", 1'b1, 8'hB1, 8'h81, 1'b0, 1'b0);
        arst_n = 1'b0;
        tick();
        expect_zero("rst.mid");
        arst_n = 1'b1;
        row4_first("rst.first", 8'hC0, 1'b0);
        push(8'hD0, 1'b0, 1'b0);
        expect_out("rst.next", 1'b1, 8'hD0, 8'hC0, 1'b0, 1'b0);

        // Overflow: ten pixels without eol into an 8-slot row
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(8'hE0 + 8'(i), 1'b0, 1'b0);
            chk($sformatf("ovf.p%0d", i), 32'(u_if.err_ovf_o), 32'(i >= 7));
        end
        tick();
        tick();
        chk("ovf.sticky", 32'(u_if.err_ovf_o), 32'd1);
        arst_n = 1'b0;
        tick();
        chk("ovf.cleared", 32'(u_if.err_ovf_o), 32'd0);
        arst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_conv_lb1
`default_nettype wire
